// File: rtl/gray_step_decoder.sv
// Gray-code step decoder.
// Synchronizes an asynchronous Gray input and decodes it to binary.
// Each clock compares the new value with the last accepted one.
// Outputs are registered: a one-cycle up, down or error pulse, plus a
// wrapping position count.
module gray_step_decoder #(
  parameter int GRAYWIDTH = 3,
  parameter int POSWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [GRAYWIDTH-1:0] gray_in,
  output logic [GRAYWIDTH-1:0] bin,
  output logic                 step_up,
  output logic                 step_down,
  output logic                 step_err,
  output logic [POSWIDTH-1:0]  position
);

  typedef enum logic {PRIME, TRACK} state_t;

  // Transition class of the current sample against bin_q.
  typedef struct packed {
    logic up;
    logic down;
    logic err;
  } step_t;

  logic [GRAYWIDTH-1:0] sync1, sync2;
  logic [GRAYWIDTH-1:0] b_now;
  logic [GRAYWIDTH-1:0] bin_q;
  logic [GRAYWIDTH-1:0] delta;
  logic [1:0]           prime_cnt;
  state_t               state;
  step_t                cls;

  // Two-flop synchronizer on the asynchronous Gray input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gray_in;
      sync2 <= sync1;
    end
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    b_now = '0;
    for (int i = GRAYWIDTH - 1; i >= 0; i--) begin
      acc      = acc ^ sync2[i];
      b_now[i] = acc;
    end
  end

  // Classify the modular difference. A zero delta matches none of the classes.
  always_comb begin
    delta    = b_now - bin_q;
    cls.up   = (delta == GRAYWIDTH'(1));
    cls.down = (delta == {GRAYWIDTH{1'b1}});
    cls.err  = (delta != '0) && !cls.up && !cls.down;
  end

  // Prime/track FSM.
  // bin_q always follows the decoded input, so a gap in tracking never
  // produces a stale step. Pulses and position are updated only in TRACK
  // while enable is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PRIME;
      prime_cnt <= '0;
      bin_q     <= '0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      step_err  <= 1'b0;
      position  <= '0;
    end else begin
      bin_q     <= b_now;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      step_err  <= 1'b0;
      case (state)
        PRIME: begin
          prime_cnt <= prime_cnt + 2'd1;
          if (prime_cnt == 2'd2) state <= TRACK;
        end
        TRACK: begin
          if (enable) begin
            step_up   <= cls.up;
            step_down <= cls.down;
            step_err  <= cls.err;
            if (cls.up)        position <= position + POSWIDTH'(1);
            else if (cls.down) position <= position - POSWIDTH'(1);
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

  assign bin = bin_q;

endmodule

// File: doc/gray_step_decoder.md
# gray_step_decoder

Decodes an externally driven Gray-code value, such as a rotary/absolute encoder or a Gray counter from another clock domain, back to binary and turns each single-code transition into a direction-qualified step. It synchronizes the asynchronous Gray input and tracks a wrap-around position count. Illegal multi-bit jumps are flagged as errors. It is the receiving end for Gray sequences produced by the team's free-running Gray generator and sits between pin/CDC logic and user counters or UI logic.

## Interface
- GRAYWIDTH, 3: width of Gray input and decoded binary; legal range ≥ 2.
- POSWIDTH, 8: width of the position accumulator.

- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  step detection enable; when low, tracking continues silently.
- gray_in  input  GRAYWIDTH  Gray code input, asynchronous to clk.
- bin  output  GRAYWIDTH  registered binary equivalent of the synchronized input.
- step_up  output  1  one-cycle pulse on a +1 transition.
- step_down  output  1  one-cycle pulse on a −1 transition.
- step_err  output  1  one-cycle pulse on any other nonzero transition.
- position  output  POSWIDTH  signed-agnostic step accumulator, modulo 2^POSWIDTH.

## Operation
- Synchronizer: two flops sync1→sync2 on gray_in; both reset to 0.
- Decode (combinational on sync2): b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] for i=W-2..0.
- Register bin_q holds the last accepted binary value; the output is bin = bin_q.
- delta = (b_now − bin_q) mod 2^GRAYWIDTH.
- State machine:
  - PRIME: entered on reset. A 2-bit counter counts 3 clocks so the synchronizer fills with real input.
  - PRIME behaviour: each cycle bin_q ← b_now, no pulses, position held. Go to TRACK when the counter reaches 2.
  - TRACK: every cycle bin_q ← b_now.
- Pulses in TRACK are valid only while enable=1:
  - delta=0: no pulse.
  - delta=1: step_up=1, position+1.
  - delta=2^W−1: step_down=1, position−1.
  - Any other delta: step_err=1, position unchanged. bin_q still resyncs to b_now.
- enable=0 in TRACK: bin_q follows b_now, all pulses 0, position held. Re-enabling never emits a stale step.
- At most one of step_up, step_down, step_err is high in any cycle.
- Position wraps freely: 2^POSWIDTH−1 +1 → 0, and 0 −1 → 2^POSWIDTH−1. No saturation.
- rst asserted at any time: return to PRIME immediately and clear all registers, regardless of state or pending pulse.

## Timing
- Reset values: bin=0, step_up=0, step_down=0, step_err=0, position=0, sync1=sync2=0, state=PRIME, prime counter=0.
- Latency: gray_in stable before rising edge N → sync1 at N, sync2 at N+1, bin/pulses/position registered at edge N+2.
  - Pulses are high for exactly the cycle following edge N+2.
- Priming: the first 3 rising edges after rst deasserts are PRIME. TRACK starts with edge 4.
  - A change whose comparison falls in PRIME produces no pulse.
- Input changes faster than 1 per clock are undefined at the sync stage. Each clock compares only the value it sampled against bin_q.
- Back-to-back legal steps on consecutive clocks each produce one pulse. Pulse lines then stay high for consecutive cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset and prime:
  - Hold gray_in=3'b110 through reset, release, wait 5 clocks → all pulses stay 0, bin=3'b100, position=0.
- Up count (W=3, enable=1):
  - Apply 000,001,011,010,110, one value per 4 clocks → four step_up pulses, each 3 edges after its change.
  - Expected end state: bin=3'b100, position=4, step_err never high.
- Down wrap:
  - From 000 after prime, apply 100 (bin 7) → step_down once, position=8'hFF.
  - Then apply 000 → step_up, position=0.
- Illegal jump:
  - From 000, apply 011 (bin 2) → step_err for 1 cycle, position unchanged, bin=2.
  - Next apply 010 (bin 3) → step_up.
- Enable gating:
  - With enable=0, walk 000→001→011 → no pulses, position held, bin=2.
  - Raise enable with input static → no pulse.
- Reset mid-operation:
  - Assert rst in the cycle a step_up is due → pulse never appears, all outputs 0 asynchronously.
  - After release, 3 PRIME cycles pass with no pulses.
